i2c_byte_tx: RTL and testbench
==============================

I2C_BYTE_TX -- requirements
Module: i2c_byte_tx

Interface
REQ-001 The block SHALL have parameter SDA_HOLD, default 2: i_clk cycles from detected SCL falling edge to SDA update (range 0..15).
REQ-002 The block SHALL have port i_clk, input, 1, the single clock; all logic is on its rising edge.
REQ-003 The block SHALL have port i_rst, input, 1, reset, synchronous and active-high.
REQ-004 The block SHALL have port i_start, input, 1, a one-cycle request to transmit i_data.
REQ-005 The block SHALL have port i_data, input, 8, the byte to send, captured when a request is accepted.
REQ-006 The block SHALL have port i_SCL, input, 1, the bus clock from the SCL generator, already synchronous to i_clk.
REQ-007 The block SHALL have port i_SDA, input, 1, the sampled bus SDA used for ACK.
REQ-008 The block SHALL have port o_SDA, output, 1, the SDA drive: 1 = release, 0 = pull low.
REQ-009 The block SHALL have port o_busy, output, 1, high from request acceptance until o_done.
REQ-010 The block SHALL have port o_done, output, 1, a one-cycle pulse at byte/ACK completion; it drives the stop generator enable.
REQ-011 The block SHALL have port o_nack, output, 1, the ACK result of the last byte: 1 = NACK.

Function
REQ-012 The block SHALL register i_SCL as scl_q; fall = scl_q & ~i_SCL, rise = ~scl_q & i_SCL, evaluated in the same cycle.
REQ-013 The block SHALL implement states IDLE, WAIT_FALL, HOLD, WAIT_RISE, ACK_FALL, ACK_HOLD, ACK_RISE, DONE.
REQ-014 In IDLE, i_start=1 SHALL capture i_data into an 8-bit shift register, clear bit_cnt, set o_busy on the next edge and go to WAIT_FALL.
REQ-015 i_start while o_busy=1 SHALL be ignored: no recapture and no state change.
REQ-016 WAIT_FALL SHALL wait for fall, then load hold_cnt=SDA_HOLD and go to HOLD; with SDA_HOLD=0, it SHALL drive o_SDA=shreg[7] in the fall cycle and go directly to WAIT_RISE.
REQ-017 HOLD SHALL decrement hold_cnt; at zero it SHALL drive o_SDA=shreg[7] and go to WAIT_RISE; SCL edges during HOLD SHALL be ignored.
REQ-018 WAIT_RISE SHALL wait for rise, then shift shreg left by one and increment bit_cnt; at bit_cnt=7 it SHALL go to ACK_FALL, else to WAIT_FALL.
REQ-019 Bits SHALL be sent MSB first; o_SDA SHALL change only while i_SCL=0.
REQ-020 ACK_FALL/ACK_HOLD SHALL mirror WAIT_FALL/HOLD, but drive o_SDA=1 (release) instead of data.
REQ-021 ACK_RISE SHALL wait for rise and register o_nack=i_SDA in that cycle, then go to DONE.
REQ-022 DONE SHALL assert o_done for exactly one cycle, clear o_busy in the same edge, keep o_SDA=1 and return to IDLE.
REQ-023 Latency: o_done SHALL be high in the cycle after the ninth rise is detected.
REQ-024 i_start coincident with the o_done cycle SHALL be ignored; acceptance is possible from the next cycle (IDLE).
REQ-025 o_nack SHALL hold its value until the next ACK_RISE sample or reset.
REQ-026 bit_cnt (3 bits) SHALL NOT wrap: the eighth bit transitions to the ACK phase.

Reset
REQ-027 i_rst=1 SHALL set state=IDLE, o_SDA=1, o_busy=0, o_done=0, o_nack=0, shreg=0, bit_cnt=0, hold_cnt=0 and scl_q=1.
REQ-028 Reset mid-byte SHALL abort at once: o_SDA released next cycle, no o_done pulse.
REQ-029 i_start while i_rst=1 SHALL be ignored.

Configuration
REQ-030 With I2C_BYTE_TX_ACK_CHK_EN defined, the ACK sample SHALL follow REQ-021 and REQ-025.
REQ-031 Without I2C_BYTE_TX_ACK_CHK_EN, ACK_RISE SHALL not sample i_SDA, o_nack SHALL be constant 0, and the timing SHALL be unchanged.

Verification
REQ-032 Byte-with-ACK scenario: SDA_HOLD=2, SCL period 20 clk, i_data=0xA5, i_SDA=0 at the ninth rise -> o_SDA bits 1,0,1,0,0,1,0,1, each 2 clk after a fall; o_done=1 one clk after the ninth rise; o_nack=0.
REQ-033 NACK scenario: i_data=0x3C, i_SDA=1 at the ninth rise -> o_nack=1 and o_done pulses once.
REQ-034 Busy-request scenario: second i_start=1 with i_data=0xFF during bit 3 of 0x12 -> the transmitted byte stays 0x12 and there is exactly one o_done.
REQ-035 Mid-byte reset scenario: i_rst=1 after the fifth rise -> next cycle o_SDA=1, o_busy=0, no o_done; a new i_start=1 with 0x55 then completes normally.
REQ-036 Zero-hold scenario: SDA_HOLD=0, i_data=0x80 -> o_SDA=1 in the first fall-detect cycle and 0 for bits 6..0.
REQ-037 Macro-off scenario: I2C_BYTE_TX_ACK_CHK_EN undefined, i_SDA=1 at ACK -> o_nack=0 and o_done timing identical to the REQ-032 scenario.

Source files
------------

// File: rtl/i2c_byte_tx.sv
// i2c_byte_tx: shifts one byte MSB-first onto SDA, then releases SDA for
// the ACK bit and optionally samples the receiver's acknowledge.
//
// Ports:
//   i_clk    - single clock, all logic on its rising edge
//   i_rst    - synchronous active-high reset
//   i_start  - one-cycle request to transmit i_data (ignored while busy)
//   i_data   - byte to send, captured on request acceptance
//   i_SCL    - bus clock from the SCL generator, synchronous to i_clk
//   i_SDA    - sampled bus SDA, used for the ACK sample
//   o_SDA    - SDA drive: 1 = release, 0 = pull low
//   o_busy   - high from acceptance until o_done
//   o_done   - one-cycle pulse at byte/ACK completion
//   o_nack   - ACK result of the last byte, 1 = NACK
//
// Parameter SDA_HOLD (0..15): i_clk cycles from a detected SCL fall to the
// SDA update.
// Optional feature macro: I2C_BYTE_TX_ACK_CHK_EN enables the ACK sample;
// without it o_nack is tied low and timing is unchanged.

module i2c_byte_tx #(
    parameter int SDA_HOLD = 2
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_start,
    input  logic [7:0] i_data,
    input  logic       i_SCL,
    input  logic       i_SDA,
    output logic       o_SDA,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_nack
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_FALL,
        HOLD,
        WAIT_RISE,
        ACK_FALL,
        ACK_HOLD,
        ACK_RISE,
        DONE
    } state_t;

    localparam logic [3:0] HOLD_INIT = 4'(SDA_HOLD);
    localparam bit         ZERO_HOLD = (SDA_HOLD == 0);

    state_t     state_q;
    logic [7:0] shreg_q;
    logic [7:0] shreg_d;
    logic [2:0] bit_cnt_q;
    logic [3:0] hold_cnt_q;
    logic       scl_q;
    logic       sda_q;
    logic       busy_q;
    logic       done_q;
    logic       fall;
    logic       rise;

`ifdef I2C_BYTE_TX_ACK_CHK_EN
    logic       nack_q;
    assign o_nack = nack_q;
`else
    logic       unused_sda;
    assign unused_sda = i_SDA;
    assign o_nack     = 1'b0;
`endif

    // Edges are seen in the same cycle the new SCL level arrives.
    assign fall    = scl_q & ~i_SCL;
    assign rise    = ~scl_q & i_SCL;
    assign shreg_d = {shreg_q[6:0], 1'b0};

    assign o_SDA  = sda_q;
    assign o_busy = busy_q;
    assign o_done = done_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= IDLE;
            shreg_q    <= 8'h00;
            bit_cnt_q  <= 3'd0;
            hold_cnt_q <= 4'd0;
            scl_q      <= 1'b1;
            sda_q      <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef I2C_BYTE_TX_ACK_CHK_EN
            nack_q     <= 1'b0;
`endif
        end else begin
            scl_q  <= i_SCL;
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (i_start) begin
                        shreg_q   <= i_data;
                        bit_cnt_q <= 3'd0;
                        busy_q    <= 1'b1;
                        state_q   <= WAIT_FALL;
                    end
                end
                WAIT_FALL: begin
                    if (fall) begin
                        if (ZERO_HOLD) begin
                            sda_q   <= shreg_q[7];
                            state_q <= WAIT_RISE;
                        end else begin
                            hold_cnt_q <= HOLD_INIT;
                            state_q    <= HOLD;
                        end
                    end
                end
                // SCL edges are deliberately ignored while counting down.
                HOLD: begin
                    if (hold_cnt_q <= 4'd1) begin
                        hold_cnt_q <= 4'd0;
                        sda_q      <= shreg_q[7];
                        state_q    <= WAIT_RISE;
                    end else begin
                        hold_cnt_q <= hold_cnt_q - 4'd1;
                    end
                end
                // bit_cnt saturates at 7: the eighth bit hands over to ACK.
                WAIT_RISE: begin
                    if (rise) begin
                        shreg_q <= shreg_d;
                        if (bit_cnt_q == 3'd7) begin
                            state_q <= ACK_FALL;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            state_q   <= WAIT_FALL;
                        end
                    end
                end
                ACK_FALL: begin
                    if (fall) begin
                        if (ZERO_HOLD) begin
                            sda_q   <= 1'b1;
                            state_q <= ACK_RISE;
                        end else begin
                            hold_cnt_q <= HOLD_INIT;
                            state_q    <= ACK_HOLD;
                        end
                    end
                end
                ACK_HOLD: begin
                    if (hold_cnt_q <= 4'd1) begin
                        hold_cnt_q <= 4'd0;
                        sda_q      <= 1'b1;
                        state_q    <= ACK_RISE;
                    end else begin
                        hold_cnt_q <= hold_cnt_q - 4'd1;
                    end
                end
                // o_done rises with the edge that detects the ninth rise.
                ACK_RISE: begin
                    if (rise) begin
`ifdef I2C_BYTE_TX_ACK_CHK_EN
                        nack_q  <= i_SDA;
`endif
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    sda_q   <= 1'b1;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_byte_tx.sv
// tb_i2c_byte_tx: randomized self-checking bench for i2c_byte_tx.
// Two instances (SDA_HOLD=2 and SDA_HOLD=0) share stimulus.

module tb_i2c_byte_tx;

    localparam int N = 260;

    logic       clk = 1'b0;
    logic       i_rst;
    logic       i_start;
    logic [7:0] i_data;
    logic       i_SCL;
    logic       i_SDA;
    logic       sda_a, busy_a, done_a, nack_a;
    logic       sda_b, busy_b, done_b, nack_b;

    int total = 0;
    int bad   = 0;

    logic       scl_arr [N];
    logic       sdi_arr [N];
    logic [7:0] expv    [N];
    logic [7:0] obsv    [N];
    int         ff      [2][9];
    int         rr      [2][9];
    logic       nack_m  [2];
    logic [7:0] cap     [2];
    int         done_cnt[2];

    always #5 clk = ~clk;

    i2c_byte_tx #(.SDA_HOLD(2)) dut_a (
        .i_clk  (clk),
        .i_rst  (i_rst),
        .i_start(i_start),
        .i_data (i_data),
        .i_SCL  (i_SCL),
        .i_SDA  (i_SDA),
        .o_SDA  (sda_a),
        .o_busy (busy_a),
        .o_done (done_a),
        .o_nack (nack_a)
    );

    i2c_byte_tx #(.SDA_HOLD(0)) dut_b (
        .i_clk  (clk),
        .i_rst  (i_rst),
        .i_start(i_start),
        .i_data (i_data),
        .i_SCL  (i_SCL),
        .i_SDA  (i_SDA),
        .o_SDA  (sda_b),
        .o_busy (busy_b),
        .o_done (done_b),
        .o_nack (nack_b)
    );

    function automatic int hval(input int i);
        return (i == 0) ? 2 : 0;
    endfunction

    function automatic logic [7:0] outs();
        return {sda_a, busy_a, done_a, nack_a,
                sda_b, busy_b, done_b, nack_b};
    endfunction

    // One transaction: build the event-level model, then drive and observe.
    // rst_rise >= 0 : reset 2 cycles after that rise index (0-based)
    // s2mode 1 : extra start mid bit 3; 2 : extra start in the done cycle
    // ack < 0 : random SDA at the ACK sample
    task automatic run(input logic [7:0] d, input int a, input int ph,
                       input int rst_rise, input int s2mode,
                       input logic [7:0] d2, input int ack);
        int rc;
        int s2;
        for (int c = 0; c < N; c++) begin
            scl_arr[c] = ((c + ph) % 20) < 10;
            sdi_arr[c] = 1'($urandom);
        end
        for (int i = 0; i < 2; i++) begin
            int t;
            t = a;
            for (int k = 0; k < 9; k++) begin
                int f;
                int r;
                f = N;
                r = N;
                for (int c = t + 1; c < N; c++)
                    if (scl_arr[c-1] && !scl_arr[c]) begin
                        f = c;
                        break;
                    end
                for (int c = f + hval(i) + 1; c < N; c++)
                    if (!scl_arr[c-1] && scl_arr[c]) begin
                        r = c;
                        break;
                    end
                ff[i][k] = f;
                rr[i][k] = r;
                t = r;
            end
        end
        rc = (rst_rise >= 0) ? rr[0][rst_rise] + 2 : -1;
        s2 = -1;
        if (s2mode == 1) s2 = ff[0][3] + 4;
        if (s2mode == 2) s2 = rr[0][8] + 1;
        if (ack >= 0) begin
            if (rr[0][8] < N) sdi_arr[rr[0][8]] = ack[0];
            if (rr[1][8] < N) sdi_arr[rr[1][8]] = ack[0];
        end
        for (int i = 0; i < 2; i++) begin
            int h;
            int r8;
            h  = hval(i);
            r8 = rr[i][8];
            for (int c = 0; c < N; c++) begin
                logic sda, busy, done, nack;
                sda  = 1'b1;
                busy = (c >= a) && (c < r8);
                done = (c == r8);
                nack = nack_m[i];
                for (int k = 0; k < 8; k++)
                    if (c >= ff[i][k] + h) sda = d[7-k];
                if (c >= ff[i][8] + h) sda = 1'b1;
`ifdef I2C_BYTE_TX_ACK_CHK_EN
                if (c >= r8) nack = sdi_arr[r8];
`endif
                if (rc >= 0 && c >= rc) begin
                    sda  = 1'b1;
                    busy = 1'b0;
                    done = 1'b0;
                    nack = 1'b0;
                end
                if (i == 0) expv[c][7:4] = {sda, busy, done, nack};
                else        expv[c][3:0] = {sda, busy, done, nack};
            end
            if (rc >= 0) nack_m[i] = 1'b0;
`ifdef I2C_BYTE_TX_ACK_CHK_EN
            else if (r8 < N) nack_m[i] = sdi_arr[r8];
`endif
        end
        cap[0] = 8'h00;
        cap[1] = 8'h00;
        done_cnt[0] = 0;
        done_cnt[1] = 0;
        for (int c = 0; c < N; c++) begin
            i_SCL   = scl_arr[c];
            i_SDA   = sdi_arr[c];
            i_rst   = (c == rc);
            i_start = (c == a) || (c == s2);
            i_data  = (c == a) ? d : ((c == s2) ? d2 : 8'($urandom));
            for (int k = 0; k < 8; k++) begin
                if (c == rr[0][k]) cap[0][7-k] = sda_a;
                if (c == rr[1][k]) cap[1][7-k] = sda_b;
            end
            @(posedge clk);
            #1;
            obsv[c] = outs();
            if (done_a) done_cnt[0]++;
            if (done_b) done_cnt[1]++;
        end
        i_start = 1'b0;
        i_rst   = 1'b0;
    endtask

    task automatic test_reset();
        i_rst   = 1'b1;
        i_SDA   = 1'b1;
        for (int c = 0; c < 4; c++) begin
            i_start = 1'b1;
            i_data  = 8'($urandom);
            i_SCL   = c[0];
            @(posedge clk);
            #1;
            total++;
            if (outs() !== 8'b1000_1000) begin
                bad++;
                $display("FAIL reset c=%0d got=%b exp=%b", c, outs(), 8'b1000_1000);
            end
        end
        i_rst   = 1'b0;
        i_start = 1'b0;
        for (int c = 0; c < 3; c++) begin
            i_SCL = 1'b1;
            @(posedge clk);
            #1;
            total++;
            if (outs() !== 8'b1000_1000) begin
                bad++;
                $display("FAIL reset_start c=%0d got=%b exp=%b", c, outs(), 8'b1000_1000);
            end
        end
        nack_m[0] = 1'b0;
        nack_m[1] = 1'b0;
    endtask

    task automatic test_ack();
        run(8'hA5, 3, int'($urandom_range(0, 19)), -1, 0, 8'h00, 0);
        for (int c = 0; c < N; c++) begin
            total++;
            if (obsv[c] !== expv[c]) begin
                bad++;
                $display("FAIL ack c=%0d got=%b exp=%b", c, obsv[c], expv[c]);
            end
        end
        for (int i = 0; i < 2; i++) begin
            total++;
            if (cap[i] !== 8'hA5 || done_cnt[i] != 1) begin
                bad++;
                $display("FAIL ack_byte dut=%0d got=%h/%0d exp=a5/1", i, cap[i], done_cnt[i]);
            end
        end
    endtask

    task automatic test_nack();
        run(8'h3C, 2, int'($urandom_range(0, 19)), -1, 0, 8'h00, 1);
        for (int c = 0; c < N; c++) begin
            total++;
            if (obsv[c] !== expv[c]) begin
                bad++;
                $display("FAIL nack c=%0d got=%b exp=%b", c, obsv[c], expv[c]);
            end
        end
        for (int i = 0; i < 2; i++) begin
            total++;
            if (cap[i] !== 8'h3C || done_cnt[i] != 1) begin
                bad++;
                $display("FAIL nack_byte dut=%0d got=%h/%0d exp=3c/1", i, cap[i], done_cnt[i]);
            end
        end
    endtask

    task automatic test_busy_request();
        run(8'h12, 4, int'($urandom_range(0, 19)), -1, 1, 8'hFF, -1);
        for (int c = 0; c < N; c++) begin
            total++;
            if (obsv[c] !== expv[c]) begin
                bad++;
                $display("FAIL busy_req c=%0d got=%b exp=%b", c, obsv[c], expv[c]);
            end
        end
        for (int i = 0; i < 2; i++) begin
            total++;
            if (cap[i] !== 8'h12 || done_cnt[i] != 1) begin
                bad++;
                $display("FAIL busy_req_byte dut=%0d got=%h/%0d exp=12/1", i, cap[i], done_cnt[i]);
            end
        end
    endtask

    task automatic test_mid_reset();
        run(8'hC3, 3, int'($urandom_range(0, 19)), 4, 0, 8'h00, -1);
        for (int c = 0; c < N; c++) begin
            total++;
            if (obsv[c] !== expv[c]) begin
                bad++;
                $display("FAIL mid_rst c=%0d got=%b exp=%b", c, obsv[c], expv[c]);
            end
        end
        for (int i = 0; i < 2; i++) begin
            total++;
            if (done_cnt[i] != 0) begin
                bad++;
                $display("FAIL mid_rst_done dut=%0d got=%0d exp=0", i, done_cnt[i]);
            end
        end
        run(8'h55, 2, int'($urandom_range(0, 19)), -1, 0, 8'h00, -1);
        for (int c = 0; c < N; c++) begin
            total++;
            if (obsv[c] !== expv[c]) begin
                bad++;
                $display("FAIL after_rst c=%0d got=%b exp=%b", c, obsv[c], expv[c]);
            end
        end
        for (int i = 0; i < 2; i++) begin
            total++;
            if (cap[i] !== 8'h55 || done_cnt[i] != 1) begin
                bad++;
                $display("FAIL after_rst_byte dut=%0d got=%h/%0d exp=55/1", i, cap[i], done_cnt[i]);
            end
        end
    endtask

    task automatic test_zero_hold();
        run(8'h80, 5, int'($urandom_range(0, 19)), -1, 0, 8'h00, 0);
        for (int c = 0; c < N; c++) begin
            total++;
            if (obsv[c] !== expv[c]) begin
                bad++;
                $display("FAIL zero_hold c=%0d got=%b exp=%b", c, obsv[c], expv[c]);
            end
        end
        total++;
        if (obsv[ff[1][0]][3] !== 1'b1 || obsv[ff[1][1]][3] !== 1'b0) begin
            bad++;
            $display("FAIL zero_hold_edge got=%b%b exp=10",
                     obsv[ff[1][0]][3], obsv[ff[1][1]][3]);
        end
        total++;
        if (cap[1] !== 8'h80) begin
            bad++;
            $display("FAIL zero_hold_byte got=%h exp=80", cap[1]);
        end
    endtask

    task automatic test_done_start();
        logic [7:0] d;
        d = 8'($urandom);
        run(d, 3, int'($urandom_range(0, 19)), -1, 2, 8'($urandom), -1);
        for (int c = 0; c < N; c++) begin
            total++;
            if (obsv[c] !== expv[c]) begin
                bad++;
                $display("FAIL done_start c=%0d got=%b exp=%b", c, obsv[c], expv[c]);
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 6; n++) begin
            logic [7:0] d;
            d = 8'($urandom);
            run(d, int'($urandom_range(1, 8)), int'($urandom_range(0, 19)),
                -1, 0, 8'h00, -1);
            for (int c = 0; c < N; c++) begin
                total++;
                if (obsv[c] !== expv[c]) begin
                    bad++;
                    $display("FAIL random n=%0d c=%0d got=%b exp=%b", n, c, obsv[c], expv[c]);
                end
            end
            for (int i = 0; i < 2; i++) begin
                total++;
                if (cap[i] !== d || done_cnt[i] != 1) begin
                    bad++;
                    $display("FAIL random_byte n=%0d dut=%0d got=%h/%0d exp=%h/1",
                             n, i, cap[i], done_cnt[i], d);
                end
            end
        end
    endtask

    initial begin
        i_rst   = 1'b1;
        i_start = 1'b0;
        i_data  = 8'h00;
        i_SCL   = 1'b1;
        i_SDA   = 1'b1;
        nack_m[0] = 1'b0;
        nack_m[1] = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_ack();
        test_nack();
        test_busy_request();
        test_mid_reset();
        test_zero_hold();
        test_done_start();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
